// File: rtl/seg7_scan_driver_if.sv
// Bundle between the multiplier side and the 4-digit scan driver.
// The slave modport is the driver, and the master modport is its user.
interface seg7_scan_driver_if;
  logic [15:0] product;
  logic        product_valid;
  logic        blank_lz;
  logic [7:0]  segments;
  logic [3:0]  anodes;
  logic        frame_done;

  modport master (
    output product, product_valid, blank_lz,
    input  segments, anodes, frame_done
  );

  modport slave (
    input  product, product_valid, blank_lz,
    output segments, anodes, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode hex scan driver with optional leading-zero blanking.
// The anode and segment outputs are registered, and they come from the next digit and next value.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [15:0]   disp_q, disp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    d_q, d_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          fd_q, fd_d;
  logic          tick;
  logic [3:0]    nib;
  logic          z3, z2, z1, blank;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] s;
    unique case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign tick = (cnt_q == CW'(REFRESH_DIV - 1));

  always_comb begin
    disp_d = bus.product_valid ? bus.product : disp_q;
    cnt_d  = tick ? '0 : cnt_q + CW'(1);
    d_d    = tick ? d_q + 2'd1 : d_q;
    fd_d   = tick && (d_q == 2'd3);
    z3     = (disp_d[15:12] == 4'h0);
    z2     = z3 && (disp_d[11:8] == 4'h0);
    z1     = z2 && (disp_d[7:4] == 4'h0);
    nib    = 4'h0;
    blank  = 1'b0;
    unique case (d_d)
      2'd0: nib = disp_d[3:0];
      2'd1: begin nib = disp_d[7:4];   blank = z1; end
      2'd2: begin nib = disp_d[11:8];  blank = z2; end
      default: begin nib = disp_d[15:12]; blank = z3; end
    endcase
    seg_d = (bus.blank_lz && blank) ? 8'hFF : hex7(nib);
    an_d  = ~(4'b0001 << d_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
      cnt_q  <= '0;
      d_q    <= '0;
      seg_q  <= 8'hC0;
      an_q   <= 4'b1110;
      fd_q   <= 1'b0;
    end else begin
      disp_q <= disp_d;
      cnt_q  <= cnt_d;
      d_q    <= d_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      fd_q   <= fd_d;
    end
  end

  assign bus.segments   = seg_q;
  assign bus.anodes     = an_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed scoreboard bench for seg7_scan_driver with REFRESH_DIV=4.
// The driver queues the expected outputs for each edge, and the monitor checks them after that edge.
module tb_seg7_scan_driver;
  logic clk = 1'b0;
  logic rst;
  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] step;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        fd;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   step  = 0;

  task automatic cyc(input logic r, input logic v, input logic [15:0] p,
                     input logic b, input logic [3:0] an,
                     input logic [7:0] seg, input logic fd);
    exp_t e;
    @(negedge clk);
    rst               = r;
    bus.product_valid = v;
    bus.product       = p;
    bus.blank_lz      = b;
    e.step = step;
    e.an   = an;
    e.seg  = seg;
    e.fd   = fd;
    q.push_back(e);
    step++;
  endtask

  task automatic frame(input logic [15:0] v, input logic [15:0] idle_p,
                       input logic b, input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3, input int nfr);
    cyc(1, 0, 16'h0, b, 4'b1110, 8'hC0, 0);
    cyc(0, 1, v, b, 4'b1110, s0, 0);
    repeat (2) cyc(0, 0, idle_p, b, 4'b1110, s0, 0);
    for (int f = 0; f < nfr; f++) begin
      repeat (4) cyc(0, 0, idle_p, b, 4'b1101, s1, 0);
      repeat (4) cyc(0, 0, idle_p, b, 4'b1011, s2, 0);
      repeat (4) cyc(0, 0, idle_p, b, 4'b0111, s3, 0);
      cyc(0, 0, idle_p, b, 4'b1110, s0, 1);
      repeat (3) cyc(0, 0, idle_p, b, 4'b1110, s0, 0);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (bus.anodes !== e.an || bus.segments !== e.seg ||
          bus.frame_done !== e.fd) begin
        bad++;
        $display("FAIL step%0d an/seg/fd got %b/%h/%b want %b/%h/%b",
                 e.step, bus.anodes, bus.segments, bus.frame_done,
                 e.an, e.seg, e.fd);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.product = '0;
    bus.product_valid = 1'b0;
    bus.blank_lz = 1'b0;
    // reset for two cycles, then a 4-cycle dwell on digit 0
    repeat (2) cyc(1, 0, 16'h0, 0, 4'b1110, 8'hC0, 0);
    repeat (3) cyc(0, 0, 16'h0, 0, 4'b1110, 8'hC0, 0);
    cyc(0, 0, 16'h0, 0, 4'b1101, 8'hC0, 0);
    // basic scan
    frame(16'h1A3F, 16'h1A3F, 0, 8'h8E, 8'hB0, 8'h88, 8'hF9, 1);
    // leading-zero blanking
    frame(16'h0042, 16'h0042, 1, 8'hA4, 8'h99, 8'hFF, 8'hFF, 1);
    frame(16'h0000, 16'h0000, 1, 8'hC0, 8'hFF, 8'hFF, 8'hFF, 1);
    frame(16'h0800, 16'h0800, 1, 8'hC0, 8'hC0, 8'h80, 8'hFF, 1);
    // blank_lz=0 on the same value shows all zeros
    frame(16'h0042, 16'h0042, 0, 8'hA4, 8'h99, 8'hC0, 8'hC0, 1);
    // valid coincident with the 0->1 tick
    cyc(1, 0, 16'h0, 0, 4'b1110, 8'hC0, 0);
    repeat (3) cyc(0, 0, 16'hFFFF, 0, 4'b1110, 8'hC0, 0);
    cyc(0, 1, 16'hFFFF, 0, 4'b1101, 8'h8E, 0);
    cyc(0, 0, 16'h0000, 0, 4'b1101, 8'h8E, 0);
    // reset mid-scan at d=2, cnt=1 with valid high
    cyc(1, 0, 16'h0, 0, 4'b1110, 8'hC0, 0);
    cyc(0, 1, 16'h5678, 0, 4'b1110, 8'h80, 0);
    repeat (2) cyc(0, 0, 16'h0, 0, 4'b1110, 8'h80, 0);
    repeat (4) cyc(0, 0, 16'h0, 0, 4'b1101, 8'hF8, 0);
    repeat (2) cyc(0, 0, 16'h0, 0, 4'b1011, 8'h82, 0);
    cyc(1, 1, 16'h9999, 0, 4'b1110, 8'hC0, 0);
    repeat (3) cyc(0, 0, 16'h9999, 0, 4'b1110, 8'hC0, 0);
    cyc(0, 0, 16'h9999, 0, 4'b1101, 8'hC0, 0);
    // hold: product changes without valid for two frames
    frame(16'h1234, 16'hABCD, 0, 8'h99, 8'hB0, 8'hA4, 8'hF9, 2);
    // back-to-back valids: the last value wins
    cyc(1, 0, 16'h0, 0, 4'b1110, 8'hC0, 0);
    cyc(0, 1, 16'h1111, 0, 4'b1110, 8'hF9, 0);
    cyc(0, 1, 16'h2222, 0, 4'b1110, 8'hA4, 0);
    cyc(0, 0, 16'h3333, 0, 4'b1110, 8'hA4, 0);
    cyc(0, 0, 16'h3333, 0, 4'b1101, 8'hA4, 0);
    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed 4-digit seven-segment driver that sits directly downstream of the Vedic multiplier. It captures the 16-bit product on a valid strobe, holds it, and scans it out as four hex digits on the board's common-anode display. Optional leading-zero blanking is supported. Segment and anode outputs are registered and glitch-free.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit. Must be ≥ 1. The default gives 1 kHz per digit at 100 MHz.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `product`  in  16  multiplier result; nibble k is shown on digit k.
- `product_valid`  in  1  when high at an edge, `product` is captured.
- `blank_lz`  in  1  1 = blank leading zero digits.
- `segments`  out  8  active-low segments: bit 7 = dp, bits 6:0 = g,f,e,d,c,b,a.
- `anodes`  out  4  active-low digit enables, one-hot-low.
- `frame_done`  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- **Internal state:**
  - `disp` (16b) holds the captured value.
  - `cnt` is a refresh counter, width clog2(REFRESH_DIV), min 1.
  - `d` (2b) is the current digit index.
- **Capture:**
  - `disp <= product` on any edge where `product_valid` = 1.
  - Otherwise `disp` holds. Changes on `product` without valid are ignored.
- **Refresh counter:**
  - `tick` = (`cnt` == REFRESH_DIV-1).
  - On tick, `cnt` goes to 0 and `d` goes to `d`+1 mod 4 (3 wraps to 0).
  - Otherwise `cnt` increments.
- **Scan order:** 0,1,2,3,0,… `anodes` values in that order: 1110, 1101, 1011, 0111.
- **Registered outputs, zero extra latency:**
  - Each edge, `anodes` and `segments` load values computed from next-`d` and next-`disp`.
  - Next-`disp` = `product` if `product_valid`, else `disp`.
  - So the lit digit and its pattern always change on the same edge.
- **Hex encoding (dp always off):**
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
  - Blank = FF.
- **Leading-zero blanking (`blank_lz` = 1):**
  - Digit 3 is blank if nibble3 = 0.
  - Digit 2 is blank if nibble3 and nibble2 are both 0.
  - Digit 1 is blank if nibbles 3..1 are all 0.
  - Digit 0 is never blanked.
  - `blank_lz` is sampled combinationally into the next-output computation, so it takes effect on the next edge.
- **`frame_done`:** registered, high for exactly the one cycle after the edge where `d` goes 3 to 0.

## Timing
- **Reset values** (on the edge where `rst` = 1, overriding valid and tick):
  - `disp`=0, `cnt`=0, `d`=0.
  - `anodes`=1110, `segments`=C0, `frame_done`=0.
- **Reset mid-scan:** same values on the next edge, regardless of `d`, `cnt` or a pending valid. The first digit advance comes REFRESH_DIV cycles after the last reset edge.
- **Digit period:** exactly REFRESH_DIV cycles. A full frame is 4·REFRESH_DIV cycles.
- **REFRESH_DIV = 1:** the digit advances every cycle, and `frame_done` pulses every 4th cycle.
- **Capture latency:** `product_valid` at edge N means `segments` shows the new value on the currently lit digit right after edge N.
- **Valid on a tick edge:** both apply at that edge. The new digit shows the new value.
- **Back-to-back valids:** each one recaptures. The last value wins.

## Test plan
- **Reset:** hold `rst` for 2 cycles, REFRESH_DIV=4.
  - Required: `anodes`=1110, `segments`=C0, `frame_done`=0.
  - Then `anodes` holds for 4 cycles before the first advance to 1101.
- **Basic scan:** REFRESH_DIV=4, `blank_lz`=0, `product`=1A3F with valid for 1 cycle.
  - Required sequence, each for 4 cycles: 1110/8E, 1101/B0, 1011/88, 0111/F9.
  - `frame_done` pulses once, one cycle after the 3-to-0 wrap edge.
- **Blanking:** `blank_lz`=1.
  - 0042: digits 3,2 = FF; digit 1 = 99; digit 0 = A4.
  - 0000: digit 0 = C0, others FF.
  - 0800: digit 3 = FF; digits 2,1,0 = 80, C0, C0.
- **Simultaneous valid and tick:** `disp`=0000, `product`=FFFF with valid on the tick edge as `d` goes 0 to 1.
  - Required: `anodes`=1101 and `segments`=8E on the same edge.
- **Mid-scan reset:** assert `rst` while `d`=2 and `cnt`=1, with valid also high.
  - Required: reset values next cycle, `disp`=0 (valid ignored), and a full REFRESH_DIV dwell on digit 0.
- **Hold:** capture 1234, then change `product` to ABCD without valid for 2 frames.
  - Required: the display stays 1234, i.e. digits 0..3 = 99, B0, A4, F9.
